imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory, which the core only reads.
- Receives a byte stream over a valid/ready handshake, checks a small frame header, and packs bytes big-endian into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- Holds the CPU (PC/pipeline) in hold until the load completes successfully.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of instruction words; count above DEPTH is an error
SYNC, 8'hA5, frame start byte

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at posedge
reload  input  1  single-cycle pulse; leaves DONE/ERR back to IDLE
imem_we  output  1  instruction-memory write enable, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
cpu_hold  output  1  1 = CPU must stay stalled/reset
load_done  output  1  level, 1 while in DONE
err  output  1  level, 1 while in ERR
err_code  output  2  00 none, 01 count > DEPTH, 10 checksum mismatch
words_loaded  output  16  words written in the current/last frame

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=1; load_done=0; err=0; err_code=00; words_loaded=0; byte counter=0; checksum accumulator=0. Memory contents are not cleared.
- States: IDLE, CNT_HI, CNT_LO, DATA, CSUM (only with the optional feature), DONE, ERR.
- in_ready=1 in IDLE, CNT_HI, CNT_LO, DATA and CSUM; in_ready=0 in DONE and ERR.
- IDLE:
  - Accepted byte == SYNC -> CNT_HI.
  - Any other byte is discarded; state stays IDLE.
- CNT_HI: accepted byte -> N[15:8]; -> CNT_LO.
- CNT_LO: accepted byte -> N[7:0], then:
  - N == 0 -> DONE (or CSUM if the feature is enabled).
  - N > DEPTH -> ERR with err_code=01.
  - Otherwise -> DATA.
  - words_loaded cleared to 0 on this edge.
- DATA:
  - Bytes are packed MSB first: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
  - On the edge that accepts byte3, the registered outputs in the following cycle are imem_we=1, imem_addr=word index, imem_wdata=assembled word, for exactly one cycle. words_loaded increments on the same edge.
  - Word index starts at 0 and increments by 1; its maximum is DEPTH-1, so it never wraps.
  - Back-to-back bytes (in_valid held high) are accepted every cycle with no bubble; the write of word k overlaps reception of word k+1.
  - in_valid=0 gaps of any length are allowed; partial words are kept.
- Last word accepted -> DONE (or CSUM); the final write still occurs in the cycle after that edge.
- DONE:
  - cpu_hold=0 and load_done=1, both registered on the edge entering DONE.
  - reload -> IDLE, with cpu_hold=1 and load_done=0 on the next edge.
- ERR:
  - err=1; cpu_hold stays 1.
  - reload -> IDLE and clears err/err_code.
  - Words already written are not rolled back.
- reload in IDLE, CNT_HI, CNT_LO, DATA or CSUM is ignored.
- rst mid-frame aborts the frame immediately; any partial word is discarded and the next frame restarts at address 0.
- reload and a byte in the same cycle in DONE/ERR: in_ready=0, so the byte is not accepted.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Enabled:
  - An 8-bit accumulator sums all data bytes (not SYNC or count bytes) mod 256.
  - After the last data byte (or after CNT_LO when N=0) the state goes to CSUM, which accepts one byte C.
  - (sum + C) mod 256 == 0 -> DONE; otherwise -> ERR with err_code=10.
- Disabled: the CSUM state and accumulator are absent; the frame ends after the last data byte and err_code=10 never occurs.

Test Plan:
- Single word (feature off): rst pulse; stream A5 00 01 12 34 56 78 -> one imem_we pulse with addr=0, wdata=32'h12345678; then load_done=1, cpu_hold=0, words_loaded=1.
- Multi-word with gaps: A5 00 03 then 12 bytes, in_valid toggled every other cycle -> exactly three writes at addr 0,1,2 with the correct big-endian words; no extra imem_we.
- Garbage before sync and oversize count: 00 FF A5 01 01 -> ERR, err_code=01, no writes, in_ready=0; reload -> IDLE, err=0.
- N=0 and reload: A5 00 00 -> DONE with no writes; reload -> cpu_hold=1; a new frame A5 00 01 DE AD BE EF writes addr 0 = DEADBEEF.
- Reset mid-load: A5 00 02 then 6 bytes, rst asserted -> all outputs at reset values immediately; a new 2-word frame writes starting at addr 0.
- Checksum (feature on): A5 00 01 01 02 03 04 F6 -> DONE; the same frame with final byte F5 -> ERR, err_code=10, but addr 0 = 32'h01020304 is still written.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: sync byte, 16-bit word count, big-endian data words.
// Define IMEM_LOADER_CSUM_EN to append and verify a trailing two's-complement checksum byte.
module imem_loader #(
    parameter int          ADDR_W = 8,
    parameter int          DEPTH  = 256,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_loaded
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_HI = 3'd1;
    localparam logic [2:0] ST_CNT_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] ST_END = ST_CSUM;
`else
    localparam logic [2:0] ST_END = ST_DONE;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]        state_r;
    logic [2:0]        state_n_s;
    logic [15:0]       count_r;
    logic [15:0]       n_s;
    logic [1:0]        byte_idx_r;
    logic [23:0]       word_r;
    logic              accept_s;
    logic              word_done_s;
    logic [1:0]        err_code_n_s;
    logic              in_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic [15:0]       words_loaded_r;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    assign accept_s = in_valid & in_ready_r;
    assign n_s      = {count_r[15:8], in_data};

    // Next-state, error-code and word-complete decode
    always_comb begin
        state_n_s    = state_r;
        err_code_n_s = err_code_r;
        word_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_data == SYNC)) begin
                    state_n_s = ST_CNT_HI;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_CNT_HI: begin
                if (accept_s) begin
                    state_n_s = ST_CNT_LO;
                end else begin
                    state_n_s = ST_CNT_HI;
                end
            end
            ST_CNT_LO: begin
                if (!accept_s) begin
                    state_n_s = ST_CNT_LO;
                end else if (n_s == 16'd0) begin
                    state_n_s = ST_END;
                end else if ({1'b0, n_s} > DEPTH_L) begin
                    state_n_s    = ST_ERR;
                    err_code_n_s = 2'b01;
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) begin
                    word_done_s = 1'b1;
                    if ((words_loaded_r + 16'd1) == count_r) begin
                        state_n_s = ST_END;
                    end else begin
                        state_n_s = ST_DATA;
                    end
                end else begin
                    state_n_s = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (!accept_s) begin
                    state_n_s = ST_CSUM;
                end else if (csum_add(csum_r, in_data) == 8'd0) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s    = ST_ERR;
                    err_code_n_s = 2'b10;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (reload) begin
                    state_n_s    = ST_IDLE;
                    err_code_n_s = 2'b00;
                end else begin
                    state_n_s = state_r;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                err_code_n_s = 2'b00;
            end
        endcase
    end

    // State, datapath and registered outputs (status flags follow the next state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            count_r        <= 16'd0;
            byte_idx_r     <= 2'd0;
            word_r         <= 24'd0;
            in_ready_r     <= 1'b1;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= '0;
            imem_wdata_r   <= 32'd0;
            cpu_hold_r     <= 1'b1;
            load_done_r    <= 1'b0;
            err_r          <= 1'b0;
            err_code_r     <= 2'b00;
            words_loaded_r <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_r         <= 8'd0;
`endif
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s != ST_DONE) && (state_n_s != ST_ERR);
            cpu_hold_r  <= (state_n_s != ST_DONE);
            load_done_r <= (state_n_s == ST_DONE);
            err_r       <= (state_n_s == ST_ERR);
            err_code_r  <= err_code_n_s;
            imem_we_r   <= word_done_s;
            if (accept_s && (state_r == ST_CNT_HI)) begin
                count_r[15:8] <= in_data;
            end
            if (accept_s && (state_r == ST_CNT_LO)) begin
                count_r[7:0]   <= in_data;
                words_loaded_r <= 16'd0;
                byte_idx_r     <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_r         <= 8'd0;
`endif
            end
            if (accept_s && (state_r == ST_DATA)) begin
                byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                csum_r     <= csum_add(csum_r, in_data);
`endif
                case (byte_idx_r)
                    2'd0:    word_r[23:16] <= in_data;
                    2'd1:    word_r[15:8]  <= in_data;
                    2'd2:    word_r[7:0]   <= in_data;
                    default: word_r        <= word_r;
                endcase
            end
            // Word index is the count of words already written in this frame
            if (word_done_s) begin
                imem_addr_r    <= words_loaded_r[ADDR_W-1:0];
                imem_wdata_r   <= {word_r, in_data};
                words_loaded_r <= words_loaded_r + 16'd1;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign err          = err_r;
    assign err_code     = err_code_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued when frames are driven
// and popped as imem_we pulses appear.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int          n_cmp;
    int          n_err;
    logic [39:0] exp_q[$];
    logic [7:0]  tx_q[$];

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .err          (err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: each imem_we pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("extra_we", 32'd1, 32'd0);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, imem_addr}, {24'd0, e[39:32]});
                chk("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic push_word(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        tx_q.push_back(d[31:24]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
    endtask

    task automatic hdr(input logic [15:0] n);
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
    endtask

    task automatic send_all(input bit gaps);
        while (tx_q.size() != 0) begin
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tx_q.pop_front();
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (load_done || err) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        chk("pending", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        // Single word
        hdr(16'd1);
        push_word(8'd0, 32'h12345678);
        send_all(1'b0);
        wait_end();
        chk("t1_done", {31'd0, load_done}, 32'd1);
        chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1_words", {16'd0, words_loaded}, 32'd1);
        chk("t1_ready", {31'd0, in_ready}, 32'd0);
        pulse_reload();
        chk("t1_rl_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t1_rl_done", {31'd0, load_done}, 32'd0);

        // Three words with gaps between bytes
        hdr(16'd3);
        push_word(8'd0, 32'hA1B2C3D4);
        push_word(8'd1, 32'h00FF0102);
        push_word(8'd2, 32'hCAFEF00D);
        send_all(1'b1);
        wait_end();
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_words", {16'd0, words_loaded}, 32'd3);
        pulse_reload();

        // Garbage before sync, count 257 exceeds depth
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        hdr(16'd257);
        send_all(1'b0);
        wait_end();
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_code", {30'd0, err_code}, 32'd1);
        chk("t3_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
        // Byte offered together with reload must be ignored
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("t3_rl_err", {31'd0, err}, 32'd0);
        chk("t3_rl_code", {30'd0, err_code}, 32'd0);

        // Empty frame
        hdr(16'd0);
        send_all(1'b0);
        wait_end();
        chk("t4_done", {31'd0, load_done}, 32'd1);
        chk("t4_err", {31'd0, err}, 32'd0);
        chk("t4_words", {16'd0, words_loaded}, 32'd0);
        pulse_reload();
        chk("t4_rl_hold", {31'd0, cpu_hold}, 32'd1);
        hdr(16'd1);
        push_word(8'd0, 32'hDEADBEEF);
        send_all(1'b0);
        wait_end();
        chk("t4b_done", {31'd0, load_done}, 32'd1);
        pulse_reload();

        // Reset in the middle of the second word
        hdr(16'd2);
        push_word(8'd0, 32'h11223344);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        send_all(1'b0);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        chk("t5_pending", exp_q.size(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hdr(16'd2);
        push_word(8'd0, 32'h89ABCDEF);
        push_word(8'd1, 32'h76543210);
        send_all(1'b0);
        wait_end();
        chk("t5_done", {31'd0, load_done}, 32'd1);
        chk("t5_words", {16'd0, words_loaded}, 32'd2);
        pulse_reload();

`ifdef IMEM_LOADER_CSUM_EN
        hdr(16'd1);
        push_word(8'd0, 32'h01020304);
        tx_q.push_back(8'hF6);
        send_all(1'b0);
        wait_end();
        chk("t6_done", {31'd0, load_done}, 32'd1);
        pulse_reload();
        hdr(16'd1);
        push_word(8'd0, 32'h01020304);
        tx_q.push_back(8'hF5);
        send_all(1'b0);
        wait_end();
        chk("t6_err", {31'd0, err}, 32'd1);
        chk("t6_code", {30'd0, err_code}, 32'd2);
        pulse_reload();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
